// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter stage of the single-cycle core.
// Selects the next PC (trap entry, mret return, taken transfer, PC+4),
// parks in an exception state on a misaligned control-transfer target
// until the CSR unit vectors the trap, and counts retired instructions.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_true,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_jalr,
    input  logic [31:0] alu_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    input  logic        mret,
    input  logic [31:0] mepc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        redirect,
    output logic        exc_valid,
    output logic [31:0] exc_tval,
    output logic [63:0] instret
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] target;
    logic        taken;
    logic        misaligned;
    logic [31:0] pc_next;
    logic        retire;
    logic        tval_load;

    // Sequential fetch address; wraps naturally at 2^32.
    assign pc_plus4 = pc + 32'd4;

    // Effective transfer target and its alignment check (JALR clears bit 0 first).
    always_comb begin
        target     = is_jalr ? {alu_target[31:1], 1'b0} : alu_target;
        taken      = is_jump | (is_branch & br_true);
        misaligned = taken & (target[1:0] != 2'b00);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a misaligned transfer only parks us in EXC when no
    // higher-priority event (trap, stall, mret) claims the cycle.
    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (!trap_req && !stall && !mret && misaligned) begin
                    state_next = EXC;
                end
            end
            EXC: begin
                if (trap_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Output and datapath-control decode, in next-PC priority order.
    always_comb begin
        pc_next    = pc;
        retire     = 1'b0;
        redirect   = 1'b0;
        tval_load  = 1'b0;
        inst_valid = 1'b0;
        exc_valid  = 1'b0;
        case (state)
            RUN: begin
                inst_valid = 1'b1;
                if (trap_req) begin
                    pc_next  = trap_vector;
                    redirect = 1'b1;
                end else if (stall) begin
                    pc_next = pc;
                end else if (mret) begin
                    pc_next  = mepc;
                    retire   = 1'b1;
                    redirect = 1'b1;
                end else if (misaligned) begin
                    tval_load = 1'b1;
                end else if (taken) begin
                    pc_next  = target;
                    retire   = 1'b1;
                    redirect = 1'b1;
                end else begin
                    pc_next = pc_plus4;
                    retire  = 1'b1;
                end
            end
            EXC: begin
                exc_valid = 1'b1;
                if (trap_req) begin
                    pc_next  = trap_vector;
                    redirect = 1'b1;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    // PC, faulting-target capture and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            exc_tval <= 32'd0;
            instret  <= 64'd0;
        end else begin
            pc <= pc_next;
            if (tval_load) begin
                exc_tval <= target;
            end
            if (retire) begin
                instret <= instret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard testbench for pc_next_unit: directed scenarios followed by
// randomized control traffic, checked against a behavioural model.
module tb_pc_next_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_true, is_branch, is_jump, is_jalr, trap_req, mret;
    logic [31:0] alu_target, trap_vector, mepc;
    logic [31:0] pc, pc_plus4, exc_tval;
    logic        inst_valid, redirect, exc_valid;
    logic [63:0] instret;

    pc_next_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_true(br_true),
        .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
        .alu_target(alu_target), .trap_req(trap_req), .trap_vector(trap_vector),
        .mret(mret), .mepc(mepc), .pc(pc), .pc_plus4(pc_plus4),
        .inst_valid(inst_valid), .redirect(redirect), .exc_valid(exc_valid),
        .exc_tval(exc_tval), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pp4;
        logic        iv;
        logic        redir;
        logic        ev;
        logic [31:0] tval;
        logic [63:0] instret;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model: mode 0 = boot, 1 = running, 2 = waiting for trap after misalignment.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_tval;
    logic [63:0] m_instret;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, expv);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", {32'd0, pc}, {32'd0, e.pc});
            chk("pc_plus4", {32'd0, pc_plus4}, {32'd0, e.pp4});
            chk("inst_valid", {63'd0, inst_valid}, {63'd0, e.iv});
            chk("redirect", {63'd0, redirect}, {63'd0, e.redir});
            chk("exc_valid", {63'd0, exc_valid}, {63'd0, e.ev});
            chk("exc_tval", {32'd0, exc_tval}, {32'd0, e.tval});
            chk("instret", instret, e.instret);
            cyc++;
        end
    end

    task automatic model_reset();
        m_mode    = 0;
        m_pc      = RPC;
        m_tval    = 32'd0;
        m_instret = 64'd0;
    endtask

    task automatic clr();
        stall = 0; br_true = 0; is_branch = 0; is_jump = 0; is_jalr = 0;
        trap_req = 0; mret = 0;
        alu_target = 32'd0; trap_vector = 32'd0; mepc = 32'd0;
    endtask

    // Compute this cycle's expected outputs, queue them, advance the model
    // across the coming edge, then move to just after that edge.
    task automatic step();
        exp_t        e;
        logic [31:0] tgt;
        logic [31:0] np;
        logic        tk;
        logic        ret;
        int          nm;
        if (rst) begin
            model_reset();
            e.pc = RPC; e.pp4 = RPC + 32'd4; e.iv = 0; e.redir = 0;
            e.ev = 0; e.tval = 0; e.instret = 0;
            q.push_back(e);
        end else begin
            e.pc = m_pc; e.pp4 = m_pc + 32'd4; e.tval = m_tval; e.instret = m_instret;
            e.iv = (m_mode == 1); e.ev = (m_mode == 2); e.redir = 0;
            np  = m_pc; ret = 0; nm = m_mode;
            tgt = is_jalr ? (alu_target & ~32'd1) : alu_target;
            tk  = is_jump || (is_branch && br_true);
            if (m_mode == 0) begin
                nm = 1;
            end else if (m_mode == 2) begin
                if (trap_req) begin np = trap_vector; nm = 1; e.redir = 1; end
            end else begin
                if (trap_req) begin
                    np = trap_vector; e.redir = 1;
                end else if (stall) begin
                    np = m_pc;
                end else if (mret) begin
                    np = mepc; ret = 1; e.redir = 1;
                end else if (tk && (tgt % 4 != 0)) begin
                    m_tval = tgt; nm = 2;
                end else if (tk) begin
                    np = tgt; ret = 1; e.redir = 1;
                end else begin
                    np = m_pc + 32'd4; ret = 1;
                end
            end
            q.push_back(e);
            m_pc = np; m_mode = nm;
            if (ret) m_instret = m_instret + 64'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        clr();
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();

        // Reset release and sequential fetch.
        rst = 0;
        clr(); step(); step(); step(); step();

        // Branch not taken, then taken, from 0x200.
        clr(); is_jump = 1; alu_target = 32'h200; step();
        clr(); is_branch = 1; alu_target = 32'h240; br_true = 0; step();
        clr(); is_jump = 1; alu_target = 32'h200; step();
        clr(); is_branch = 1; alu_target = 32'h240; br_true = 1; step();
        clr(); step();

        // JALR clears bit 0; JAL to a misaligned target enters EXC.
        clr(); is_jump = 1; is_jalr = 1; alu_target = 32'h301; step();
        clr(); step();
        clr(); is_jump = 1; alu_target = 32'h302; step();
        clr(); step();
        clr(); mret = 1; mepc = 32'h900; is_jump = 1; alu_target = 32'h700; stall = 1; step();
        clr(); trap_req = 1; trap_vector = 32'h80; step();
        clr(); step();

        // Priority collisions.
        clr(); trap_req = 1; trap_vector = 32'h400; mret = 1; mepc = 32'h500;
        is_branch = 1; br_true = 1; alu_target = 32'h600; stall = 1; step();
        clr(); stall = 1; mret = 1; mepc = 32'h500; step();
        clr(); step();

        // PC wrap-around.
        clr(); is_jump = 1; alu_target = 32'hFFFF_FFFC; step();
        clr(); step();
        clr(); step();

        // Retired-instruction counter wrap.
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        clr(); step();
        clr(); step();

        // Asynchronous reset while parked in EXC.
        clr(); is_jump = 1; alu_target = 32'h402; step();
        clr(); step();
        rst = 1;
        #1;
        rst = 0;
        model_reset();
        clr(); step();
        clr(); step();
        clr(); step();

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            clr();
            trap_req    = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            mret        = ($urandom_range(0, 9) == 0);
            is_jump     = ($urandom_range(0, 3) == 0);
            is_branch   = ($urandom_range(0, 3) == 0);
            br_true     = $urandom_range(0, 1) == 1;
            is_jalr     = is_jump && ($urandom_range(0, 1) == 1);
            alu_target  = $urandom;
            if ($urandom_range(0, 3) != 0) alu_target[1:0] = 2'b00;
            trap_vector = $urandom & 32'hFFFF_FFFC;
            mepc        = $urandom & 32'hFFFF_FFFC;
            step();
        end
        clr();
        step();

        // Every queued expectation must have been consumed.
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
